// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I decode definitions.
//   - OP_* : 7-bit base-ISA opcode values
//   - imm_type_e : immediate format selected by opcode
//   - *_LSB : bit positions of the fixed instruction fields
package rv_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned REG_FIELD_W = 5;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate generator for RV32I.
//   instr    in   32  instruction word
//   imm      out  DW  sign-extended immediate (0 for R-type and illegal opcodes)
//   imm_type out      immediate format selected by the opcode
//   illegal  out  1   opcode is not part of the RV32I base set
module imm_gen
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_type_e             imm_type,
    output logic                  illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[OPCODE_LSB +: OPCODE_W])
            OP_LUI, OP_AUIPC:                        imm_type = IMM_U;
            OP_JAL:                                  imm_type = IMM_J;
            OP_BRANCH:                               imm_type = IMM_B;
            OP_STORE:                                imm_type = IMM_S;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_MISC_MEM, OP_SYSTEM:                  imm_type = IMM_I;
            OP_OP:                                   imm_type = IMM_NONE;
            default: begin
                imm_type = IMM_NONE;
                illegal  = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage between fetch and execute.
// Drives the register-file read addresses and registers the decoded fields so
// they line up with the file's one-cycle registered read data.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch handshake, in_instr instruction word
//   flush                    drop the held instruction (redirect)
//   rf_rd1_addr/rf_rd2_addr  register-file read addresses
//   rf_dout1/rf_dout2        register-file read data (1 cycle after address)
//   wb_en/wb_addr/wb_data    writeback port, same write as the file sees
//   out_valid/out_ready      execute handshake
//   out_rs1_data/out_rs2_data, out_rd, out_funct3, out_opcode, out_imm, out_illegal
// Build option: ID_WB_BYPASS_EN patches the file's read-during-write
// (pre-write data) with the captured writeback value; otherwise the
// hazard logic must leave a bubble after a write. x0 reads 0 in both builds.
module id_stage
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic [ADDRESS_WIDTH-1:0] rf_rd1_addr,
    output logic [ADDRESS_WIDTH-1:0] rf_rd2_addr,
    input  logic [DATA_WIDTH-1:0]    rf_dout1,
    input  logic [DATA_WIDTH-1:0]    rf_dout2,
    input  logic                     wb_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_rs1_data,
    output logic [DATA_WIDTH-1:0]    out_rs2_data,
    output logic [ADDRESS_WIDTH-1:0] out_rd,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_opcode,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic                     out_illegal
);

    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] rs1_in;
    logic [ADDRESS_WIDTH-1:0] rs2_in;
    logic [ADDRESS_WIDTH-1:0] rs1_q;
    logic [ADDRESS_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0]    imm_dec;
    logic                     illegal_dec;
    imm_type_e                imm_type_unused;
    logic                     hit1_q;
    logic                     hit2_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr    (in_instr),
        .imm      (imm_dec),
        .imm_type (imm_type_unused),
        .illegal  (illegal_dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign rs1_in = ADDRESS_WIDTH'(in_instr[RS1_LSB +: REG_FIELD_W]);
    assign rs2_in = ADDRESS_WIDTH'(in_instr[RS2_LSB +: REG_FIELD_W]);

    // Addresses follow the incoming instruction on accept so the file data
    // arrives together with the registered fields; otherwise re-read the held
    // registers so writes during a stall show up on rf_dout.
    assign rf_rd1_addr = accept ? rs1_in : rs1_q;
    assign rf_rd2_addr = accept ? rs2_in : rs2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_opcode  <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_rd      <= ADDRESS_WIDTH'(in_instr[RD_LSB +: REG_FIELD_W]);
            out_funct3  <= in_instr[FUNCT3_LSB +: FUNCT3_W];
            out_opcode  <= in_instr[OPCODE_LSB +: OPCODE_W];
            out_imm     <= imm_dec;
            out_illegal <= illegal_dec;
            rs1_q       <= rs1_in;
            rs2_q       <= rs2_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_WB_BYPASS_EN
    // The file returns pre-write data for a same-cycle read and write, so
    // remember that a write hit the address being read and substitute it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            wb_data_q <= '0;
        end else begin
            hit1_q    <= wb_en && (wb_addr == rf_rd1_addr) && (wb_addr != '0);
            hit2_q    <= wb_en && (wb_addr == rf_rd2_addr) && (wb_addr != '0);
            wb_data_q <= wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
    assign hit1_q    = 1'b0;
    assign hit2_q    = 1'b0;
    assign wb_data_q = '0;
`endif

    assign out_rs1_data = (rs1_q == '0) ? '0 : (hit1_q ? wb_data_q : rf_dout1);
    assign out_rs2_data = (rs2_q == '0) ? '0 : (hit2_q ? wb_data_q : rf_dout2);

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic [4:0]  rf_rd1_addr;
    logic [4:0]  rf_rd2_addr;
    logic [31:0] rf_dout1;
    logic [31:0] rf_dout2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [6:0]  out_opcode;
    logic [31:0] out_imm;
    logic        out_illegal;

    int checks = 0;
    int passes = 0;

    vec_t sb[$];
    vec_t vecs[13];
    vec_t idle_v;

    // Register-file model: registered read returns pre-write contents.
    logic [31:0] regs[32];
    logic [31:0] regs_prev[32];

    always #5 clk = ~clk;

    id_stage #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_rd2_addr (rf_rd2_addr),
        .rf_dout1    (rf_dout1),
        .rf_dout2    (rf_dout2),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data),
        .out_rd      (out_rd),
        .out_funct3  (out_funct3),
        .out_opcode  (out_opcode),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always @(posedge clk) begin
        rf_dout1  <= regs[rf_rd1_addr];
        rf_dout2  <= regs[rf_rd2_addr];
        regs_prev <= regs;
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
            regs[0] <= 32'hDEAD_BEEF;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

    function automatic logic [31:0] exp_rs(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        return regs[a];
`else
        return regs_prev[a];
`endif
    endfunction

    task automatic check_out(input vec_t e);
        chk("rd",       32'(out_rd),      32'(e.rd));
        chk("funct3",   32'(out_funct3),  32'(e.f3));
        chk("opcode",   32'(out_opcode),  32'(e.op));
        chk("imm",      out_imm,          e.imm);
        chk("illegal",  32'(out_illegal), 32'(e.ill));
        chk("rs1_data", out_rs1_data,     exp_rs(e.instr[19:15]));
        chk("rs2_data", out_rs2_data,     exp_rs(e.instr[24:20]));
    endtask

    task automatic tick(input vec_t v, input logic iv, input logic ordy, input logic fl,
                        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        vec_t e;
        @(negedge clk);
        in_valid  = iv;
        in_instr  = v.instr;
        out_ready = ordy;
        flush     = fl;
        wb_en     = wbe;
        wb_addr   = wba;
        wb_data   = wbd;
        #1;
        if (out_valid && (out_ready || flush)) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: got out_valid=1 expected no pending instruction");
            end else begin
                e = sb.pop_front();
                if (!flush) check_out(e);
            end
        end
        if (in_valid && in_ready && !flush) sb.push_back(v);
    endtask

    task automatic drain();
        for (int n = 0; n < 8 && sb.size() != 0; n++) tick(idle_v, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old_x1;
        vecs[0]  = '{32'hFFB00093, 5'd1,  3'd0, 7'h13, 32'hFFFFFFFB, 1'b0}; // addi x1,x0,-5
        vecs[1]  = '{32'hFE000EE3, 5'd29, 3'd0, 7'h63, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[2]  = '{32'h008000EF, 5'd1,  3'd0, 7'h6F, 32'h00000008, 1'b0}; // jal x1,8
        vecs[3]  = '{32'h123450B7, 5'd1,  3'd5, 7'h37, 32'h12345000, 1'b0}; // lui
        vecs[4]  = '{32'h0020A423, 5'd8,  3'd2, 7'h23, 32'h00000008, 1'b0}; // sw x2,8(x1)
        vecs[5]  = '{32'hFE20AE23, 5'd28, 3'd2, 7'h23, 32'hFFFFFFFC, 1'b0}; // sw x2,-4(x1)
        vecs[6]  = '{32'h002081B3, 5'd3,  3'd0, 7'h33, 32'h00000000, 1'b0}; // add x3,x1,x2
        vecs[7]  = '{32'hFFFFF297, 5'd5,  3'd7, 7'h17, 32'hFFFFF000, 1'b0}; // auipc
        vecs[8]  = '{32'hFFF12203, 5'd4,  3'd2, 7'h03, 32'hFFFFFFFF, 1'b0}; // lw x4,-1(x2)
        vecs[9]  = '{32'h00008067, 5'd0,  3'd0, 7'h67, 32'h00000000, 1'b0}; // jalr x0,0(x1)
        vecs[10] = '{32'h0000007F, 5'd0,  3'd0, 7'h7F, 32'h00000000, 1'b1}; // illegal
        vecs[11] = '{32'hFFDFF06F, 5'd0,  3'd7, 7'h6F, 32'hFFFFFFFC, 1'b0}; // jal x0,-4
        vecs[12] = '{32'h00209863, 5'd16, 3'd1, 7'h63, 32'h00000010, 1'b0}; // bne x1,x2,16
        idle_v   = '{32'h0, 5'd0, 3'd0, 7'h0, 32'h0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid),   32'h0);
        chk("rst_out_rd",    32'(out_rd),      32'h0);
        chk("rst_out_imm",   out_imm,          32'h0);
        chk("rst_illegal",   32'(out_illegal), 32'h0);
        chk("rst_rs1_data",  out_rs1_data,     32'h0);
        rst = 1'b0;

        // ADDI after reset: one-cycle latency, x0 source reads 0.
        tick(vecs[0], 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick(idle_v, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_rd",    32'(out_rd),    32'h1);
        chk("addi_imm",   out_imm,        32'hFFFFFFFB);
        chk("addi_rs1",   out_rs1_data,   32'h0);
        drain();

        // Back-to-back table with writebacks to the source being read.
        foreach (vecs[i])
            tick(vecs[i], 1'b1, 1'b1, 1'b0, 1'(i % 2), vecs[i].instr[19:15], $urandom);
        drain();

        // Read during write of x1.
        old_x1 = regs[1];
        tick(vecs[6], 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_1234);
        tick(idle_v, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
`ifdef ID_WB_BYPASS_EN
        chk("rdw_rs1", out_rs1_data, 32'h0000_1234);
`else
        chk("rdw_rs1", out_rs1_data, old_x1);
`endif
        drain();

        // Write to x0 in the file: x0 still reads 0.
        tick(vecs[0], 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h5555_AAAA);
        drain();

        // Stall for three cycles while fetch keeps offering.
        tick(vecs[6], 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick(vecs[12], 1'b1, 1'b0, 1'b0, 1'(c == 1), 5'd2, 32'h0000_CAFE);
            chk("stall_in_ready", 32'(in_ready),  32'h0);
            chk("stall_valid",    32'(out_valid), 32'h1);
            chk("stall_addr1",    32'(rf_rd1_addr), 32'd1);
            chk("stall_addr2",    32'(rf_rd2_addr), 32'd2);
            chk("stall_rd",       32'(out_rd),    32'd3);
        end
        tick(vecs[12], 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drain();

        // Flush of a held instruction, then of a same-cycle accept.
        tick(vecs[7], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick(vecs[8], 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick(idle_v, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_held_valid", 32'(out_valid), 32'h0);
        tick(vecs[8], 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick(idle_v, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_acc_valid", 32'(out_valid), 32'h0);
        tick(vecs[4], 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drain();

        // Asynchronous reset while stalled.
        tick(vecs[2], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick(vecs[3], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_rd",    32'(out_rd),    32'h0);
        chk("async_rst_ready", 32'(in_ready),  32'h1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(vecs[10], 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
